// File: rtl/divu_if.sv
`default_nettype none
// ============================================================================
// Module      : divu_if
// Description : Request/result bundle between the pipeline and divu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
interface divu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (output start, a, b, input hi, lo, busy, done);
    modport slave  (input start, a, b, output hi, lo, busy, done);
endinterface
`default_nettype wire

// File: rtl/divu_iter.sv
`default_nettype none
// ============================================================================
// Module      : divu_iter
// Description : Iterative restoring unsigned divider, one quotient bit/clock.
//               Quotient to lo, remainder to hi.
// Revision    : 1.0 - initial release
// ============================================================================
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  wire       clk,
    input  wire       reset,
    divu_if.slave     bus
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // The remainder stays below the divisor between steps, so WIDTH bits hold
    // it; only the shifted value needs the extra bit for the compare.
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_div;
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_quo   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_quo   <= bus.a;
                    r_div   <= bus.b;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_RUN;
                end
            end else begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_lo    <= w_quo_nx;
                    r_hi    <= w_rem_nx;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_divu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_divu_iter
// Description : Self-checking bench for divu_iter: vector table, corner
//               sequences and a randomized sweep against a/b, a%b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divu_iter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    divu_if #(.WIDTH(32)) bus ();

    divu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start strobe in the current (negedge) cycle; returns one cycle later.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Counts sampled cycles since the start cycle until done, bounded.
    task automatic wait_done(input int n0, output int n, output int busy_n);
        n      = n0;
        busy_n = n0 - 1;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
        end
        check("done timeout", 32'(bus.done), 32'd1);
    endtask

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] q, output logic [31:0] r);
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
    endfunction

    initial begin
        vec_t        tbl[8];
        int          n;
        int          busy_n;
        logic [31:0] ra, rb, eq, er;
        logic        saw_done;

        n_cmp  = 0;
        n_fail = 0;
        tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1] = '{32'd81,         32'd9,          32'd9,          32'd0};
        tbl[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        tbl[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[4] = '{32'd3,          32'd10,         32'd0,          32'd3};
        tbl[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        tbl[6] = '{32'd0,          32'd5,          32'd0,          32'd0};
        tbl[7] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset hi",   bus.hi, 32'd0);
        check("reset lo",   bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table entries run back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].a, tbl[i].b);
            check("done drops on accept", 32'(bus.done), 32'd0);
            wait_done(1, n, busy_n);
            check("latency", 32'(n), 32'd33);
            check("busy cycles", 32'(busy_n), 32'd32);
            check("table lo", bus.lo, tbl[i].lo);
            check("table hi", bus.hi, tbl[i].hi);
        end

        @(negedge clk);
        check("done one pulse", 32'(bus.done), 32'd0);

        // Start while busy must be ignored.
        issue(32'd1000, 32'd3);
        check("lo held on accept", bus.lo, 32'd715827882);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(11, n, busy_n);
        check("ignored start latency", 32'(n), 32'd33);
        check("ignored start lo", bus.lo, 32'd333);
        check("ignored start hi", bus.hi, 32'd1);
        @(negedge clk);

        // Asynchronous abort mid-division.
        issue(32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("no done after abort", 32'(saw_done), 32'd0);
        issue(32'd50, 32'd8);
        wait_done(1, n, busy_n);
        check("after abort lo", bus.lo, 32'd6);
        check("after abort hi", bus.hi, 32'd2);

        // Randomized back-to-back sweep with biased operand ranges.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       begin ra = $urandom; rb = $urandom; end
                1:       begin ra = $urandom; rb = $urandom_range(1, 255); end
                2:       begin ra = $urandom_range(0, 1000); rb = $urandom; end
                default: begin ra = $urandom; rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31); end
            endcase
            model(ra, rb, eq, er);
            issue(ra, rb);
            wait_done(1, n, busy_n);
            check("rand latency", 32'(n), 32'd33);
            check("rand lo", bus.lo, eq);
            check("rand hi", bus.hi, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
